sram_rd_streamer: RTL and testbench
===================================

Name: sram_rd_streamer

Overview:
Read-side sequencer for the 128b x 2048 activation/weight SRAM. On a start command it drives the SRAM's CEN/REN/A pins to read len consecutive words from base_addr. Each word is captured into a small skid buffer and emitted on a valid/ready stream toward the L0/PE-array feeder. It owns the SRAM's read port for the duration of a burst and never writes.

Parameters:
DW, 128, data word width; must match the SRAM D/Q width
AW, 11, SRAM address width
LEN_W, 12, width of the length field (max burst 2048 words)
DEPTH, 2, skid-buffer entries; minimum 2

Ports:
CLK  input  1  rising-edge clock, shared with the SRAM
RST_N  input  1  asynchronous active-low reset
start  input  1  burst request, one-cycle pulse; sampled only in IDLE
base_addr  input  AW  first SRAM address; latched on an accepted start
len  input  LEN_W  number of words to read; latched on an accepted start
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when a burst completes
sram_cen  output  1  SRAM chip enable, active-low
sram_wen  output  1  SRAM write enable; tied 0
sram_ren  output  1  SRAM read enable, active-high
sram_a  output  AW  SRAM address
sram_q  input  DW  SRAM read data; combinational, valid in the same cycle as A
out_data  output  DW  stream data, head of the skid buffer
out_valid  output  1  stream valid
out_ready  input  1  stream ready from the consumer
out_last  output  1  high with the final word of a burst

Behaviour:
- Reset (async, RST_N=0): state=IDLE, buffer empty, counters 0. Outputs: busy=0, done=0, out_valid=0, out_last=0, out_data=0, sram_cen=1, sram_ren=0, sram_a=0, sram_wen=0.
- Reset mid-burst aborts the burst. In-flight data is discarded and no done pulse is produced.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches base_addr and len, clears issue_cnt.
  - len!=0 goes to RUN; len==0 goes straight to DONE.
- start is ignored in all states other than IDLE; the latched registers are not disturbed.
- Read issue happens in RUN when issue_cnt<len_q and buffer count<DEPTH. In an issue cycle:
  - sram_cen=0, sram_ren=1, sram_a=base_q+issue_cnt (mod 2^AW, so it wraps 2047 to 0).
  - sram_q is pushed into the buffer at the closing clock edge, and issue_cnt increments.
  - The issue decision uses registered count only; there is no combinational path from out_ready to the sram_* outputs.
- In every non-issue cycle: sram_cen=1, sram_ren=0, sram_a holds its last value.
- RUN moves to DRAIN on the edge where issue_cnt reaches len_q.
- Stream rules:
  - out_valid = buffer non-empty; out_data = head entry.
  - A pop occurs on out_valid & out_ready. Push and pop may coincide in one cycle; count is then unchanged.
  - out_data and out_last stay stable while out_valid=1 and out_ready=0.
  - out_last is high on the word whose pop index equals len_q-1.
- DRAIN moves to DONE on the edge where the out_last word pops.
- DONE lasts one cycle with done=1, then returns to IDLE. busy=1 in RUN, DRAIN and DONE.
- Latency: start accepted at edge E0 → first issue in the cycle after E0 → out_valid in the cycle after that, i.e. 2 cycles.
- Throughput: with DEPTH=2 and out_ready held at 1, one word per cycle sustained.
- Backpressure: with out_ready=0 the buffer fills to DEPTH, then issue stalls with sram_cen=1. No word is lost or duplicated.

Optional Feature:
Macro STREAM_STALL_CNT_EN.
- Defined: adds output port stall_cnt, 16 bits. It clears on an accepted start and increments every cycle with out_valid=1 and out_ready=0, saturating at 16'hFFFF. It holds its value after done until the next start; reset value 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle → sram_cen=1, sram_ren=0, busy=0, out_valid=0; start with RST_N=0 has no effect.
- start, base=16, len=4, out_ready=1 → sram_a=16,17,18,19 on 4 consecutive cycles; out_data equals mem[16..19] in order; out_last on 4th word; done pulses 1 cycle after last pop; busy drops the cycle after.
- base=2046, len=4 → addresses 2046,2047,0,1 (wrap); data order preserved.
- len=8 with out_ready toggling 1,0,0,1,... → exactly 8 words, in order, none duplicated. sram_cen=1 whenever count=2. With STREAM_STALL_CNT_EN, stall_cnt equals the counted valid&!ready cycles.
- len=0 → busy high 1 cycle, done pulse, zero SRAM reads, out_valid never asserts.
- RST_N low during RUN after 3 words → all outputs return to reset values immediately, no done. A new start, base=0, len=2, then completes normally.

Source files
------------

// File: rtl/sram_rd_streamer.sv
// Read-side burst sequencer for the 128b x 2048 SRAM, streaming words through a skid buffer.
// Optional stall counter output enabled by defining STREAM_STALL_CNT_EN.
module sram_rd_streamer #(
    parameter int unsigned DW    = 128,
    parameter int unsigned AW    = 11,
    parameter int unsigned LEN_W = 12,
    parameter int unsigned DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             sram_cen,
    output logic             sram_wen,
    output logic             sram_ren,
    output logic [AW-1:0]    sram_a,
    input  logic [DW-1:0]    sram_q,
    output logic [DW-1:0]    out_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef STREAM_STALL_CNT_EN
    output logic [15:0]      stall_cnt,
`endif
    output logic             out_last
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             r_state;
    logic [AW-1:0]      r_base;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_issue_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_cen;
    logic               r_ren;
    logic [AW-1:0]      r_a;

    logic [DW-1:0]      r_mem  [DEPTH];
    logic               r_last [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    state_t             w_state_nxt;
    logic [AW-1:0]      w_base_nxt;
    logic [LEN_W-1:0]   w_len_nxt;
    logic [LEN_W-1:0]   w_issue_cnt_nxt;
    logic [LEN_W-1:0]   w_issue_inc;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               w_issue_go;
    logic               w_valid;
    logic               w_push;
    logic               w_pop;
    logic               w_head_last;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_valid     = (r_count != '0);
    assign w_head_last = r_last[r_rd_ptr];
    assign w_push      = r_ren;
    assign w_pop       = w_valid & out_ready;
    assign w_issue_inc = r_issue_cnt + LEN_W'(1);

    // Next-state and next-issue decode; the issue flag is registered so the SRAM pins see no path from out_ready
    always_comb begin
        w_state_nxt     = r_state;
        w_base_nxt      = r_base;
        w_len_nxt       = r_len;
        w_issue_cnt_nxt = r_issue_cnt;
        w_count_nxt     = r_count;
        w_issue_go      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_base_nxt      = base_addr;
                    w_len_nxt       = len;
                    w_issue_cnt_nxt = '0;
                    w_state_nxt     = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_push) begin
                    w_issue_cnt_nxt = w_issue_inc;
                    if (w_issue_inc == r_len)
                        w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_pop && w_head_last)
                    w_state_nxt = DONE;
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
        w_issue_go = (w_state_nxt == RUN) && (w_issue_cnt_nxt < w_len_nxt)
                     && (w_count_nxt < CNT_W'(DEPTH));
    end

    // Control FSM with registered SRAM and status outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= IDLE;
            r_base      <= '0;
            r_len       <= '0;
            r_issue_cnt <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cen       <= 1'b1;
            r_ren       <= 1'b0;
            r_a         <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_base      <= w_base_nxt;
            r_len       <= w_len_nxt;
            r_issue_cnt <= w_issue_cnt_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_done      <= (w_state_nxt == DONE);
            r_cen       <= ~w_issue_go;
            r_ren       <= w_issue_go;
            if (w_issue_go)
                r_a <= w_base_nxt + AW'(w_issue_cnt_nxt);
        end
    end

    // Skid buffer: each entry carries its last-word flag alongside the data
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i]  <= '0;
                r_last[i] <= 1'b0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr]  <= sram_q;
                r_last[r_wr_ptr] <= (r_issue_cnt == r_len - LEN_W'(1));
                r_wr_ptr         <= ptr_inc(r_wr_ptr);
            end
            if (w_pop)
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= w_count_nxt;
        end
    end

`ifdef STREAM_STALL_CNT_EN
    logic [15:0] r_stall;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            r_stall <= '0;
        else if ((r_state == IDLE) && start)
            r_stall <= '0;
        else if (w_valid && !out_ready && (r_stall != 16'hFFFF))
            r_stall <= r_stall + 16'd1;
    end

    assign stall_cnt = r_stall;
`endif

    assign busy      = r_busy;
    assign done      = r_done;
    assign sram_cen  = r_cen;
    assign sram_wen  = 1'b0;
    assign sram_ren  = r_ren;
    assign sram_a    = r_a;
    assign out_data  = r_mem[r_rd_ptr];
    assign out_valid = w_valid;
    assign out_last  = w_valid & w_head_last;

endmodule

// File: tb/tb_sram_rd_streamer.sv
// Directed bench for sram_rd_streamer: bench-side SRAM, burst-level stream model, per-cycle compare.
module tb_sram_rd_streamer;

    localparam int unsigned DW = 128;
    localparam int unsigned AW = 11;
    localparam int unsigned LEN_W = 12;
    localparam int DEPTH = 2;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             start;
    logic [AW-1:0]    base_addr;
    logic [LEN_W-1:0] len;
    logic             busy, done, sram_cen, sram_wen, sram_ren, out_valid, out_ready, out_last;
    logic [AW-1:0]    sram_a;
    logic [DW-1:0]    sram_q, out_data;
`ifdef STREAM_STALL_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    sram_rd_streamer dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .sram_cen(sram_cen), .sram_wen(sram_wen),
        .sram_ren(sram_ren), .sram_a(sram_a), .sram_q(sram_q), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef STREAM_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .out_last(out_last)
    );

    always #5 CLK = ~CLK;

    // Every address holds a distinct word
    function automatic logic [DW-1:0] word_of(input int a);
        logic [31:0] x;
        x = 32'(a);
        return {x ^ 32'hDEAD0000, x * 32'd7, ~x, 32'h12340000 + x};
    endfunction

    assign sram_q = word_of(int'(sram_a));

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int exp_base = 0, exp_len = 0;
    int rd_cnt = 0, pop_cnt = 0, valid_cnt = 0, done_cnt = 0, stall_model = 0;
    int first_rd_cyc = -1, first_valid_cyc = -1, last_pop_cyc = -1, done_cyc = -1, start_cyc = 0;
    int last_a = 0;
    int addr_log[$];
    logic [DW-1:0] pop_log[$];
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic prev_last;
    logic rdy_mode = 1'b0;
    int k = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    always @(posedge CLK) cyc++;

    // Consumer ready: steady 1, or the repeating 1,0,0,1 pattern
    always @(posedge CLK) begin
        #1;
        out_ready = rdy_mode ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
        k++;
    end

    // Per-cycle compare against the burst-level model
    always @(negedge CLK) begin
        int occ;
        if (!RST_N) begin
            prev_stall = 1'b0;
            last_a = 0;
        end else begin
            occ = rd_cnt - pop_cnt;
            chk("sram_wen", sram_wen, 0);
            chk("sram_cen_vs_ren", sram_cen, !sram_ren);
            chk("out_valid_occ", out_valid, occ > 0);
            if (sram_ren) begin
                chk("sram_a", sram_a, (exp_base + rd_cnt) % 2048);
                chk("issue_when_full", occ < DEPTH, 1);
                if (rd_cnt == 0) first_rd_cyc = cyc;
                addr_log.push_back(int'(sram_a));
                last_a = int'(sram_a);
                rd_cnt++;
            end else begin
                chk("sram_a_hold", sram_a, last_a);
            end
            if (out_valid) begin
                if (valid_cnt == 0) first_valid_cyc = cyc;
                valid_cnt++;
                if (prev_stall) begin
                    chk("stall_data_stable", out_data, prev_data);
                    chk("stall_last_stable", out_last, prev_last);
                end
                if (out_ready) begin
                    chk("out_data", out_data, word_of((exp_base + pop_cnt) % 2048));
                    chk("out_last", out_last, pop_cnt == exp_len - 1);
                    pop_log.push_back(out_data);
                    pop_cnt++;
                    last_pop_cyc = cyc;
                end else begin
                    stall_model++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic kick(input int b, input int l);
        @(posedge CLK); #1;
        exp_base = b; exp_len = l;
        rd_cnt = 0; pop_cnt = 0; valid_cnt = 0; stall_model = 0;
        first_rd_cyc = -1; first_valid_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
        addr_log.delete(); pop_log.delete();
        start = 1'b1; base_addr = AW'(b); len = LEN_W'(l);
        start_cyc = cyc;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (done) begin got = 1'b1; break; end
        end
        #1;
        chk({nm, "_done_seen"}, got, 1);
        chk({nm, "_busy_at_done"}, busy, 1);
        chk({nm, "_reads"}, rd_cnt, exp_len);
        chk({nm, "_pops"}, pop_cnt, exp_len);
        chk({nm, "_done_after_last_pop"}, done_cyc - last_pop_cyc, 1);
        chk({nm, "_first_read_lat"}, first_rd_cyc - start_cyc, 1);
        chk({nm, "_first_valid_lat"}, first_valid_cyc - start_cyc, 2);
        @(negedge CLK);
        chk({nm, "_busy_drop"}, busy, 0);
        chk({nm, "_done_one_cycle"}, done, 0);
`ifdef STREAM_STALL_CNT_EN
        chk({nm, "_stall_cnt"}, stall_cnt, stall_model);
`endif
    endtask

    initial begin
        int dc;
        logic got;
        RST_N = 1'b0; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b1;

        // Start while held in reset must do nothing
        repeat (2) @(posedge CLK);
        #1; start = 1'b1; base_addr = AW'(7); len = LEN_W'(3);
        @(negedge CLK);
        chk("rst_busy", busy, 0);
        chk("rst_cen", sram_cen, 1);
        chk("rst_ren", sram_ren, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_a", sram_a, 0);
        chk("rst_data", out_data, 0);
        @(posedge CLK); #1;
        start = 1'b0; RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        chk("idle_busy", busy, 0);
        chk("idle_cen", sram_cen, 1);

        // Basic burst, full throughput
        kick(16, 4);
        wait_done("b16");
        if (addr_log.size() == 4) begin
            chk("b16_a0", addr_log[0], 16);
            chk("b16_a1", addr_log[1], 17);
            chk("b16_a2", addr_log[2], 18);
            chk("b16_a3", addr_log[3], 19);
        end else chk("b16_addr_count", addr_log.size(), 4);
        if (pop_log.size() > 0)
            chk("b16_word0", pop_log[0], {32'hDEAD0010, 32'h00000070, 32'hFFFFFFEF, 32'h12340010});
        else chk("b16_pop_count", pop_log.size(), 4);

        // Address wrap at the top of the array
        kick(2046, 4);
        wait_done("wrap");
        if (addr_log.size() == 4) begin
            chk("wrap_a0", addr_log[0], 2046);
            chk("wrap_a1", addr_log[1], 2047);
            chk("wrap_a2", addr_log[2], 0);
            chk("wrap_a3", addr_log[3], 1);
        end else chk("wrap_addr_count", addr_log.size(), 4);

        // Backpressure with a stray start mid-burst that must be ignored
        rdy_mode = 1'b1;
        kick(40, 8);
        @(posedge CLK); #1;
        start = 1'b1; base_addr = AW'(500); len = LEN_W'(1);
        @(posedge CLK); #1;
        start = 1'b0;
        wait_done("bp");
        rdy_mode = 1'b0;
        chk("bp_stalled", stall_model > 0, 1);

        // Zero-length burst
        kick(5, 0);
        @(negedge CLK);
        chk("len0_busy", busy, 1);
        chk("len0_done", done, 1);
        @(negedge CLK);
        chk("len0_busy_drop", busy, 0);
        chk("len0_done_drop", done, 0);
        chk("len0_reads", rd_cnt, 0);
        chk("len0_valid", valid_cnt, 0);

        // Reset mid-burst after three words
        kick(100, 8);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK); #1;
            if (pop_cnt >= 3) begin got = 1'b1; break; end
        end
        chk("mid_three_popped", got, 1);
        dc = done_cnt;
        RST_N = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_last", out_last, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_cen", sram_cen, 1);
        chk("mid_rst_ren", sram_ren, 0);
        chk("mid_rst_a", sram_a, 0);
        rd_cnt = 0; pop_cnt = 0;
        repeat (2) @(posedge CLK);
        #1; RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        chk("mid_no_done", done_cnt, dc);
        chk("mid_idle_busy", busy, 0);
        kick(0, 2);
        wait_done("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
